res_out_reader: RTL

- Drain-side consumer of the res_out interface of the C-tile ping-pong buffer.
- Detects each toggle of output_trigger, which marks one completed C tile ready in the readable bank.
- Sweeps the bank with rd_en/rd_addr, absorbs the fixed SRAM read latency, and streams words out on a valid/ready port with m_last on the final word of each tile.
- Runs in the res_out clock domain (clk = res_out clk).

---
 rtl/res_out_pkg.sv | 13 +
 rtl/res_fifo.sv | 59 +++++
 rtl/res_out_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/res_out_pkg.sv
// Shared definitions for the res_out ping-pong buffer and its drain-side reader.
package res_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    localparam int RES_RD_DELAY = 2;
    localparam int RES_ADDR_WTH = 2;

endpackage

// File: rtl/res_fifo.sv
// Small synchronous FIFO; head is the oldest entry and is valid whenever !empty.
module res_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/res_out_reader.sv
// Drains one C tile per output_trigger toggle from the res_out bank and streams
// it on a valid/ready port, issuing reads only when the output FIFO has room.
module res_out_reader
    import res_out_pkg::*;
#(
    parameter int D_WIDTH     = 64,
    parameter int ADDR_WTH    = RES_ADDR_WTH,
    parameter int RD_DELAY    = RES_RD_DELAY,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WTH     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                output_trigger,
    output logic                rd_en,
    output logic [ADDR_WTH-1:0] rd_addr,
    input  logic [D_WIDTH-1:0]  rd_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [D_WIDTH-1:0]  m_data,
    output logic                m_last,
    output logic                busy,
    output logic [CNT_WTH-1:0]  tile_cnt,
    output logic                overflow_err
);

    localparam int DEPTH_W = $clog2(FIFO_DEPTH+1);
    localparam int INF_W   = $clog2(RD_DELAY+1);
    localparam int CRD_W   = $clog2(FIFO_DEPTH+RD_DELAY+1);
    localparam logic [ADDR_WTH-1:0] LAST_ADDR = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ref_q, ref_d;
    drain_state_e           state_q, state_d;
    logic [ADDR_WTH-1:0]    addr_q, addr_d;
    logic                   pending_q, pending_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_WTH-1:0]     cnt_q, cnt_d;
    logic [RD_DELAY-1:0]    vld_pipe_q, vld_pipe_d;
    logic [RD_DELAY-1:0]    last_pipe_q, last_pipe_d;

    logic                   tgl_det;
    logic                   start;
    logic                   issue;
    logic                   credit_ok;
    logic [INF_W-1:0]       inflight;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [D_WIDTH:0]       fifo_head;
    logic [DEPTH_W-1:0]     fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;

    assign tgl_det = sync_q[SYNC_STAGES-1] ^ ref_q;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_DELAY; i++) begin
            inflight = inflight + INF_W'(vld_pipe_q[i]);
        end
    end

    // Words issued but not yet popped never exceed the FIFO, so a push always fits.
    assign credit_ok = (CRD_W'(fifo_count) + CRD_W'(inflight)) < CRD_W'(FIFO_DEPTH);
    assign issue     = (state_q == DRAIN) && credit_ok && !fifo_full;
    assign fifo_push = vld_pipe_q[RD_DELAY-1];
    assign fifo_pop  = m_valid && m_ready;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], output_trigger};
        ref_d     = sync_q[SYNC_STAGES-1];
        state_d   = state_q;
        addr_d    = addr_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        start     = 1'b0;

        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (addr_q == LAST_ADDR);
        for (int i = 1; i < RD_DELAY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end

        case (state_q)
            IDLE:  start = tgl_det || pending_q;
            DRAIN: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = FLUSH;
                        addr_d  = '0;
                    end
                end
            end
            FLUSH: begin
                if (inflight == '0) begin
                    start = tgl_det || pending_q;
                    if (!start) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // One event is consumed per tile start; if two are present, one stays pending.
        if (start) begin
            state_d   = DRAIN;
            addr_d    = '0;
            pending_d = pending_q && tgl_det;
        end else if (tgl_det) begin
            if (pending_q) ovf_d = 1'b1;
            else           pending_d = 1'b1;
        end

        cnt_d = cnt_q + CNT_WTH'(fifo_pop && m_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            ref_q       <= 1'b0;
            state_q     <= IDLE;
            addr_q      <= '0;
            pending_q   <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            sync_q      <= sync_d;
            ref_q       <= ref_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    res_fifo #(
        .WIDTH (D_WIDTH+1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({last_pipe_q[RD_DELAY-1], rd_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rd_en        = issue;
    assign rd_addr      = addr_q;
    assign m_valid      = !fifo_empty;
    assign m_data       = fifo_head[D_WIDTH-1:0];
    assign m_last       = fifo_head[D_WIDTH];
    assign busy         = (state_q != IDLE);
    assign tile_cnt     = cnt_q;
    assign overflow_err = ovf_q;

endmodule
